// File: rtl/booth_pkg.sv
// Shared types and default sizing for the booth multiplier issue/capture stage.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } issue_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_TAG_WIDTH  = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned PROD_WIDTH     = 2 * DEF_DATA_WIDTH;
  localparam int unsigned PTR_WIDTH      = $clog2(DEF_FIFO_DEPTH);

  // Pointer width for a FIFO of the given depth; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous FIFO holding packed {tag, q, m} operand entries.
module booth_op_fifo
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned PW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);

  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/booth_issue_ctrl.sv
// Operand-issue and result-capture stage around a non-pipelined booth_multiplier.
module booth_issue_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_m,
  input  logic [DATA_WIDTH-1:0]   in_q,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    mul_start,
  output logic [DATA_WIDTH-1:0]   mul_m,
  output logic [DATA_WIDTH-1:0]   mul_q,
  input  logic                    mul_ready,
  input  logic [2*DATA_WIDTH-1:0] mul_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  localparam int unsigned PW  = ptr_width(FIFO_DEPTH);
  localparam int unsigned OPW = TAG_WIDTH + 2 * DATA_WIDTH;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  issue_state_t           state;
  logic [TAG_WIDTH-1:0]   op_tag;
  logic [OPW-1:0]         fifo_wdata;
  logic [OPW-1:0]         fifo_rdata;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [PW:0]            fifo_count;
  logic [DATA_WIDTH-1:0]  head_m;
  logic [DATA_WIDTH-1:0]  head_q;
  logic [TAG_WIDTH-1:0]   head_tag;
  logic                   capture;

  assign fifo_wdata = {in_tag, in_q, in_m};
  assign head_m     = fifo_rdata[DATA_WIDTH-1:0];
  assign head_q     = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_tag   = fifo_rdata[OPW-1:2*DATA_WIDTH];

  // Held low during reset so producers cannot push into a FIFO being cleared.
  assign in_ready  = rst_n && !fifo_full;
  assign fifo_push = in_valid && in_ready;

  always_comb begin
    capture  = (state == WAIT_DONE) && mul_ready && (!out_valid || out_ready);
    fifo_pop = !fifo_empty && ((state == IDLE) || capture);
  end

  booth_op_fifo #(
    .WIDTH (OPW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A capture that finds the FIFO non-empty pops and relaunches in the same
  // cycle, matching what IDLE would do one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mul_start  <= 1'b0;
      mul_m      <= '0;
      mul_q      <= '0;
      op_tag     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      mul_start <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (fifo_pop) begin
        mul_m  <= head_m;
        mul_q  <= head_q;
        op_tag <= head_tag;
      end
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= LAUNCH;
        end
        LAUNCH: begin
          if (mul_ready) begin
            mul_start <= 1'b1;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!mul_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (capture) begin
            out_result <= mul_result;
            out_tag    <= op_tag;
            out_valid  <= 1'b1;
            state      <= fifo_empty ? IDLE : LAUNCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  count_bound: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= FULL_CNT);

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Directed bench for booth_issue_ctrl with a behavioural multi-cycle multiplier.
module tb_booth_issue_ctrl;
  import booth_pkg::*;

  localparam int unsigned DW         = 16;
  localparam int unsigned TW         = 4;
  localparam int unsigned FD         = 4;
  localparam int unsigned MUL_CYCLES = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_m = '0;
  logic [DW-1:0]     in_q = '0;
  logic [TW-1:0]     in_tag = '0;
  logic              mul_start;
  logic [DW-1:0]     mul_m;
  logic [DW-1:0]     mul_q;
  logic              mul_ready;
  logic [2*DW-1:0]   mul_result;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [2*DW-1:0]   out_result;
  logic [TW-1:0]     out_tag;

  int total = 0;
  int bad = 0;
  int push_timeouts = 0;
  int start_pulses = 0;
  int start_errs = 0;
  int cyc = 0;
  logic prev_start = 1'b0;
  logic [TW+PROD_WIDTH-1:0] sb[$];

  always #5 clk = ~clk;

  booth_issue_ctrl #(
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_m       (in_m),
    .in_q       (in_q),
    .in_tag     (in_tag),
    .mul_start  (mul_start),
    .mul_m      (mul_m),
    .mul_q      (mul_q),
    .mul_ready  (mul_ready),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  // Multiplier stand-in: ready drops one cycle after start, product appears MUL_CYCLES later.
  logic                 mb_ready;
  logic                 mb_pend;
  logic [7:0]           mb_cnt;
  logic signed [DW-1:0] mb_a;
  logic signed [DW-1:0] mb_b;
  logic [2*DW-1:0]      mb_res;
  logic signed [2*DW-1:0] ea;
  logic signed [2*DW-1:0] eb;
  assign ea = mb_a;
  assign eb = mb_b;
  assign mul_ready  = mb_ready;
  assign mul_result = mb_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_ready <= 1'b1;
      mb_pend  <= 1'b0;
      mb_cnt   <= '0;
      mb_a     <= '0;
      mb_b     <= '0;
      mb_res   <= '0;
    end else if (mb_pend) begin
      mb_pend  <= 1'b0;
      mb_ready <= 1'b0;
      mb_cnt   <= 8'(MUL_CYCLES);
    end else if (!mb_ready) begin
      mb_cnt <= mb_cnt - 8'd1;
      if (mb_cnt == 8'd1) begin
        mb_ready <= 1'b1;
        mb_res   <= ea * eb;
      end
    end else if (mul_start) begin
      mb_pend <= 1'b1;
      mb_a    <= mul_m;
      mb_b    <= mul_q;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) sb.push_back({out_tag, out_result});
    if (mul_start) begin
      start_pulses <= start_pulses + 1;
      if (!mul_ready || prev_start) start_errs <= start_errs + 1;
    end
    prev_start <= mul_start;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic push_op(input logic [DW-1:0] m, input logic [DW-1:0] q, input logic [TW-1:0] tag);
    int n;
    logic done;
    in_valid = 1'b1;
    in_m = m;
    in_q = q;
    in_tag = tag;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        n++;
        if (n >= 300) begin
          push_timeouts++;
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int i = 0; i < budget && sb.size() < n; i++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #11;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("FAIL reset_out_result: got %h want 0", out_result); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
    total++; if (mul_m !== '0 || mul_q !== '0) begin bad++; $display("FAIL reset_mul_ops: got %h/%h want 0/0", mul_m, mul_q); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    idle_cycles(2);
  endtask

  task automatic test_single;
    int lat;
    sb.delete();
    out_ready = 1'b1;
    push_op(16'd3, 16'hFFFB, 4'd1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid && lat == 0) lat = i;
    end
    total++; if (lat != 13) begin bad++; $display("FAIL single_latency: got %0d want 13", lat); end
    wait_results(1, 50);
    total++; if (sb.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", sb.size()); end
    total++; if (sb.size() < 1 || sb[0] !== {4'd1, 32'hFFFFFFF1}) begin
      bad++; $display("FAIL single_result: got %h want %h", (sb.size() > 0) ? sb[0] : 'x, {4'd1, 32'hFFFFFFF1});
    end
    idle_cycles(3);
  endtask

  task automatic test_back_to_back;
    int c0;
    logic [TW+PROD_WIDTH-1:0] exp_q [4];
    exp_q[0] = {4'd0, 32'd42};
    exp_q[1] = {4'd1, 32'd64};
    exp_q[2] = {4'd2, 32'd65534};
    exp_q[3] = {4'd3, 32'hFFFF8000};
    sb.delete();
    out_ready = 1'b1;
    c0 = cyc;
    push_op(16'd7, 16'd6, 4'd0);
    push_op(16'hFFF8, 16'hFFF8, 4'd1);
    push_op(16'h7FFF, 16'd2, 4'd2);
    push_op(16'h8000, 16'd1, 4'd3);
    total++; if (cyc - c0 != 4) begin bad++; $display("FAIL burst_no_stall: got %0d cycles want 4", cyc - c0); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL burst_in_ready: got %b want 1", in_ready); end
    wait_results(4, 200);
    total++; if (sb.size() != 4) begin bad++; $display("FAIL burst_count: got %0d want 4", sb.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= sb.size() || sb[i] !== exp_q[i]) begin
        bad++; $display("FAIL burst_result%0d: got %h want %h", i, (i < sb.size()) ? sb[i] : 'x, exp_q[i]);
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_backpressure;
    int p0, vcount, changes, drops;
    logic seen;
    logic [2*DW-1:0] held;
    logic [TW-1:0] held_tag;
    logic [TW+PROD_WIDTH-1:0] exp_q [3];
    exp_q[0] = {4'd5, 32'd25};
    exp_q[1] = {4'd6, 32'hFFFFFFEB};
    exp_q[2] = {4'd7, 32'hFFFFD8F0};
    sb.delete();
    out_ready = 1'b0;
    p0 = start_pulses;
    push_op(16'd5, 16'd5, 4'd5);
    push_op(16'hFFFD, 16'd7, 4'd6);
    push_op(16'd100, 16'hFF9C, 4'd7);
    seen = 1'b0; vcount = 0; changes = 0; drops = 0; held = '0; held_tag = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        vcount++;
        if (!seen) begin
          seen = 1'b1; held = out_result; held_tag = out_tag;
        end else if (out_result !== held || out_tag !== held_tag) changes++;
      end else if (seen) drops++;
    end
    total++; if (vcount < 80) begin bad++; $display("FAIL bp_valid_held: got %0d cycles want >=80", vcount); end
    total++; if (changes != 0 || drops != 0) begin bad++; $display("FAIL bp_stable: got %0d changes %0d drops want 0", changes, drops); end
    total++; if ({held_tag, held} !== exp_q[0]) begin bad++; $display("FAIL bp_held_value: got %h want %h", {held_tag, held}, exp_q[0]); end
    total++; if (dut.state !== WAIT_DONE) begin bad++; $display("FAIL bp_state: got %0d want %0d", dut.state, WAIT_DONE); end
    total++; if (start_pulses - p0 != 2) begin bad++; $display("FAIL bp_launches: got %0d want 2", start_pulses - p0); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_no_handshake: got %0d want 0", sb.size()); end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_results(3, 200);
    total++; if (sb.size() != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", sb.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= sb.size() || sb[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_result%0d: got %h want %h", i, (i < sb.size()) ? sb[i] : 'x, exp_q[i]);
      end
    end
    idle_cycles(5);
  endtask

  task automatic test_full_fifo;
    int idx;
    logic acc;
    logic [TW+PROD_WIDTH-1:0] exp_v;
    sb.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 48; k++) begin
      in_valid = (idx < 6);
      in_m = 16'(idx + 1);
      in_q = 16'd10;
      in_tag = 4'(8 + idx);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (k == 7) begin
        total++; if (idx != 5) begin bad++; $display("FAIL full_accepted_early: got %0d want 5", idx); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready_early: got %b want 0", in_ready); end
      end
    end
    in_valid = 1'b0;
    total++; if (idx != 6) begin bad++; $display("FAIL full_accepted_total: got %0d want 6", idx); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready_late: got %b want 0", in_ready); end
    out_ready = 1'b1;
    wait_results(6, 400);
    total++; if (sb.size() != 6) begin bad++; $display("FAIL full_count: got %0d want 6", sb.size()); end
    for (int i = 0; i < 6; i++) begin
      exp_v = {4'(8 + i), 32'(10 * (i + 1))};
      total++;
      if (i >= sb.size() || sb[i] !== exp_v) begin
        bad++; $display("FAIL full_result%0d: got %h want %h", i, (i < sb.size()) ? sb[i] : 'x, exp_v);
      end
    end
    idle_cycles(5);
  endtask

  task automatic test_reset_midop;
    logic reached;
    sb.delete();
    out_ready = 1'b1;
    push_op(16'd9, 16'd9, 4'd3);
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(negedge clk);
      if (dut.state == WAIT_DONE) reached = 1'b1;
    end
    total++; if (!reached) begin bad++; $display("FAIL midop_reach_wait: got 0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
      bad++; $display("FAIL midop_out_cleared: got %b/%h/%h want 0/0/0", out_valid, out_result, out_tag);
    end
    total++; if (mul_start !== 1'b0 || mul_m !== '0 || mul_q !== '0) begin
      bad++; $display("FAIL midop_mul_cleared: got %b/%h/%h want 0/0/0", mul_start, mul_m, mul_q);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midop_in_ready: got %b want 0", in_ready); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);
    push_op(16'd2, 16'd2, 4'd2);
    wait_results(1, 60);
    idle_cycles(30);
    total++; if (sb.size() != 1) begin bad++; $display("FAIL midop_count: got %0d want 1", sb.size()); end
    total++; if (sb.size() < 1 || sb[0] !== {4'd2, 32'd4}) begin
      bad++; $display("FAIL midop_result: got %h want %h", (sb.size() > 0) ? sb[0] : 'x, {4'd2, 32'd4});
    end
  endtask

  task automatic test_start_pulse;
    total++; if (start_errs != 0) begin bad++; $display("FAIL start_shape: got %0d bad pulses want 0", start_errs); end
    total++; if (start_pulses != 16) begin bad++; $display("FAIL start_count: got %0d want 16", start_pulses); end
    total++; if (push_timeouts != 0) begin bad++; $display("FAIL push_timeout: got %0d want 0", push_timeouts); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_fifo();
    test_reset_midop();
    test_start_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
